// File: rtl/uart_prog_sequencer.sv
// rtl/uart_prog_sequencer.sv - UART-driven instruction-memory reprogramming sequencer
// Hunts for the sync word, streams 32-bit words to the memory controller, closes with a terminator.
module uart_prog_sequencer #(
  parameter int ADDR_W       = 10,
  parameter int MAX_WORDS    = 1024,
  parameter int BYTE_TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              prog_ena,
  output logic [31:0]       prog_data,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [ADDR_W:0]   word_count,
  output logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [31:0] SYNC_WORD = 32'hDEADBEEF;
  localparam logic [31:0] TERM_WORD = 32'hBADDAB99;
  localparam int          TW        = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(BYTE_TIMEOUT - 1);
  localparam logic [ADDR_W:0] WORDS_MAX  = (ADDR_W + 1)'(MAX_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_LOAD = 2'd2,
    ST_TERM = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       shift_q, shift_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              word_ready_q, word_ready_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              err_q, err_d;
  logic [31:0]       prog_data_q, prog_data_d;
  logic [31:0]       window;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      timer_q      <= '0;
      word_ready_q <= 1'b0;
      word_count_q <= '0;
      err_q        <= 1'b0;
      prog_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      byte_cnt_q   <= byte_cnt_d;
      timer_q      <= timer_d;
      word_ready_q <= word_ready_d;
      word_count_q <= word_count_d;
      err_q        <= err_d;
      prog_data_q  <= prog_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    timer_d      = timer_q;
    word_ready_d = 1'b0;
    word_count_d = word_count_q;
    err_d        = err_q;
    prog_data_d  = prog_data_q;
    prog_ena     = 1'b0;
    done         = 1'b0;
    window       = {shift_q[23:0], rx_data};

    // Bytes are accepted in every state so nothing is lost during strobe cycles.
    if (rx_valid) begin
      shift_d    = window;
      byte_cnt_d = byte_cnt_q + 2'd1;
    end

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (rx_valid && window == SYNC_WORD) begin
          state_d      = ST_SYNC;
          byte_cnt_d   = '0;
          word_count_d = '0;
          err_d        = 1'b0;
        end
      end
      ST_SYNC: begin
        prog_ena    = 1'b1;
        prog_data_d = SYNC_WORD;
        timer_d     = '0;
        state_d     = ST_LOAD;
      end
      ST_LOAD: begin
        timer_d      = rx_valid ? '0 : timer_q + TW'(1);
        word_ready_d = rx_valid && (byte_cnt_q == 2'd3);
        if (word_ready_q) begin
          if (shift_q == TERM_WORD) begin
            prog_ena    = 1'b1;
            prog_data_d = TERM_WORD;
            done        = 1'b1;
            state_d     = ST_IDLE;
          end else if (word_count_q == WORDS_MAX) begin
            err_d   = 1'b1;
            state_d = ST_TERM;
          end else begin
            prog_ena     = 1'b1;
            prog_data_d  = shift_q;
            word_count_d = word_count_q + 1'b1;
          end
        end else if (!rx_valid && timer_q == TIMER_LAST) begin
          // A byte arriving in this same cycle counts as activity and cancels the timeout.
          err_d   = 1'b1;
          state_d = ST_TERM;
        end
      end
      ST_TERM: begin
        prog_ena    = 1'b1;
        prog_data_d = TERM_WORD;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign prog_data  = prog_data_d;
  assign prog_addr  = word_count_q[ADDR_W-1:0];
  assign word_count = word_count_q;
  assign cpu_halt   = (state_q != ST_IDLE);
  assign busy       = cpu_halt;
  assign err        = err_q;

endmodule
